// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver: special scan
// codes, the queued event layout and the frame receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] KEYUP   = 8'hF0;
  localparam logic [7:0] EXTEND  = 8'hE0;
  localparam logic [7:0] KB_ERR0 = 8'h00;
  localparam logic [7:0] KB_ERR1 = 8'hFF;
  localparam int         EVENT_W = 10;

  typedef struct packed {
    logic       keyup;
    logic       extend;
    logic [7:0] code;
  } ps2_event_t;

  typedef enum logic [1:0] {
    BYTE_CODE,
    BYTE_KEYUP,
    BYTE_EXTEND,
    BYTE_KBERR
  } byte_kind_t;

  typedef enum logic [1:0] {
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic byte_kind_t classify(input logic [7:0] b);
    byte_kind_t kind;
    kind = BYTE_CODE;
    if (b == KEYUP)                        kind = BYTE_KEYUP;
    else if (b == EXTEND)                  kind = BYTE_EXTEND;
    else if (b == KB_ERR0 || b == KB_ERR1) kind = BYTE_KBERR;
    return kind;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame
// shifter with odd-parity/stop checking and an inter-edge watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       abort
);

  localparam int         WDW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     clk_sync;
  logic [1:0]     data_sync;
  logic           filt_clk;
  logic [7:0]     filt_cnt;
  logic           strobe;
  logic           sample;

  rx_state_t      state, state_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift, shift_next;
  logic           par_bit, par_bit_next;
  logic [WDW-1:0] wd_cnt, wd_cnt_next;
  logic           bv_next, perr_next, ferr_next, to_next, abort_next;

  // Idle bus is high, so synchronisers come out of reset at 1 to avoid a fake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= 8'd0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= 8'd0;
    end else if (filt_cnt == FILT_LAST) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= 8'd0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  assign strobe  = filt_clk & ~clk_sync[1] & (filt_cnt == FILT_LAST);
  assign sample  = data_sync[1];
  assign rx_byte = shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RX_START;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      par_bit     <= 1'b0;
      wd_cnt      <= '0;
      byte_valid  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      par_bit     <= par_bit_next;
      wd_cnt      <= wd_cnt_next;
      byte_valid  <= bv_next;
      parity_err  <= perr_next;
      frame_err   <= ferr_next;
      timeout_err <= to_next;
      abort       <= abort_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    par_bit_next = par_bit;
    wd_cnt_next  = wd_cnt;
    bv_next      = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;
    to_next      = 1'b0;
    abort_next   = 1'b0;
    if (strobe) begin
      wd_cnt_next = '0;
      case (state)
        RX_START: begin
          // A high start bit means we are out of step; wait for the next edge.
          if (sample) begin
            ferr_next = 1'b1;
          end else begin
            state_next   = RX_DATA;
            bit_idx_next = 3'd0;
          end
        end
        RX_DATA: begin
          shift_next   = {sample, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = RX_PARITY;
        end
        RX_PARITY: begin
          par_bit_next = sample;
          state_next   = RX_STOP;
        end
        RX_STOP: begin
          state_next = RX_START;
          perr_next  = ~(^{shift, par_bit});
          ferr_next  = ~sample;
          bv_next    = sample & (^{shift, par_bit});
          abort_next = ~bv_next;
        end
        default: state_next = RX_START;
      endcase
    end else if (state != RX_START) begin
      if (wd_cnt == WD_LAST) begin
        state_next  = RX_START;
        wd_cnt_next = '0;
        to_next     = 1'b1;
        abort_next  = 1'b1;
      end else begin
        wd_cnt_next = wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx_fifo.sv
// PS/2 keyboard receiver top: prefix decoder, optional repeat suppression,
// show-ahead event FIFO with occupancy count, and sticky error flags.
module ps2_keyboard_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 3,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DEDUP          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic             valid,
  output logic             keyup,
  output logic             extend,
  output logic [7:0]       scancode,
  output logic [FIFO_AW:0] count,
  output logic             overflow,
  output logic             err_parity,
  output logic             err_frame,
  output logic             err_timeout,
  output logic             kb_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         rx_byte;
  logic               byte_valid, rx_parity_err, rx_frame_err, rx_timeout, rx_abort;

  logic               keyup_flag, extend_flag;
  ps2_event_t         last_evt, new_evt, head;
  byte_kind_t         kind;
  logic               push_req, kb_set;

  logic [EVENT_W-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [FIFO_AW:0]   count_reg;
  logic               full, pop, wr_en, ovf_set;

  logic [4:0]         err_set, err_reg;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .parity_err (rx_parity_err),
    .frame_err  (rx_frame_err),
    .timeout_err(rx_timeout),
    .abort      (rx_abort)
  );

  always_comb begin
    kind     = classify(rx_byte);
    new_evt  = '{keyup: keyup_flag, extend: extend_flag, code: rx_byte};
    push_req = 1'b0;
    kb_set   = 1'b0;
    if (byte_valid) begin
      if (kind == BYTE_CODE)
        push_req = (DEDUP == 0) || (new_evt != last_evt);
      kb_set = (kind == BYTE_KBERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyup_flag  <= 1'b0;
      extend_flag <= 1'b0;
      last_evt    <= '0;
    end else if (rx_abort) begin
      keyup_flag  <= 1'b0;
      extend_flag <= 1'b0;
    end else if (byte_valid) begin
      case (kind)
        BYTE_KEYUP:  keyup_flag  <= 1'b1;
        BYTE_EXTEND: extend_flag <= 1'b1;
        default: begin
          keyup_flag  <= 1'b0;
          extend_flag <= 1'b0;
          if (kind == BYTE_CODE) last_evt <= new_evt;
        end
      endcase
    end
  end

  // Occupancy never exceeds DEPTH, so the count MSB alone flags full.
  assign full    = count_reg[FIFO_AW];
  assign valid   = (count_reg != '0);
  assign pop     = rd_en & valid;
  assign wr_en   = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign rd_next = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= new_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_reg <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered head read; a write landing on the next head slot is forwarded
  // because the array still holds the old word this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          head <= '0;
    else if (wr_en && wr_ptr == rd_next) head <= new_evt;
    else                              head <= mem[rd_next];
  end

  assign keyup    = head.keyup;
  assign extend   = head.extend;
  assign scancode = head.code;
  assign count    = count_reg;

  assign err_set = {kb_set, rx_timeout, rx_frame_err, rx_parity_err, ovf_set};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_reg <= '0;
    else     err_reg <= err_set | (err_reg & {5{~clr_err}});
  end

  assign overflow    = err_reg[0];
  assign err_parity  = err_reg[1];
  assign err_frame   = err_reg[2];
  assign err_timeout = err_reg[3];
  assign kb_overrun  = err_reg[4];

endmodule
